// File: rtl/key_event_pkg.sv
// key_event_pkg: keycodes, channel indices and default repeat timing for the key front end.
package key_event_pkg;
    localparam logic [7:0] KC_LEFT     = 8'h04;
    localparam logic [7:0] KC_RIGHT    = 8'h07;
    localparam logic [7:0] KC_KONAMI   = 8'h1a;
    localparam logic [7:0] KC_SOFTDROP = 8'h18;
    localparam logic [7:0] KC_ROTL     = 8'h14;
    localparam logic [7:0] KC_ROTR     = 8'h08;
    localparam logic [7:0] KC_HOLD     = 8'h0f;
    localparam logic [7:0] KC_CLEARALL = 8'h13;
    localparam int CH_LEFT     = 0;
    localparam int CH_RIGHT    = 1;
    localparam int CH_KONAMI   = 2;
    localparam int CH_SOFTDROP = 3;
    localparam int CH_ROTL     = 4;
    localparam int CH_ROTR     = 5;
    localparam int DAS_DEFAULT = 16;
    localparam int ARR_DEFAULT = 4;
endpackage

// File: rtl/key_repeat_timer.sv
// key_repeat_timer: shared hold counter producing DAS/ARR repeat pulses for the held channel.
module key_repeat_timer import key_event_pkg::*; #(
    parameter int NUM_KEYS = 6,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK = NUM_KEYS'(6'b000011),
    parameter int DAS_DELAY = DAS_DEFAULT,
    parameter int ARR_PERIOD = ARR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] held,
    input  logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] rep
);
    localparam int TW = $clog2(DAS_DELAY);
    logic [TW-1:0] count;
    logic run, wrap;
    assign run = |(held & REPEAT_MASK);
    // a press on a new key discards the old key's count, even if it was about to fire
    assign wrap = run && !(|press) && count == TW'(DAS_DELAY - 1);
    assign rep = wrap ? (held & REPEAT_MASK) : '0;
    always_ff @(posedge clk) begin
        if (rst || |press || !(|held))
            count <= '0;
        else if (wrap)
            count <= TW'(DAS_DELAY - ARR_PERIOD);
        else if (run)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: decodes keycodes into channels, latches press/repeat events as pending
// flags and presents them lowest index first over a valid/ready handshake.
module key_event_arbiter import key_event_pkg::*; #(
    parameter int NUM_KEYS = 6,
    parameter int KEYCODE_W = 8,
    parameter logic [NUM_KEYS*KEYCODE_W-1:0] KEYMAP =
        (NUM_KEYS*KEYCODE_W)'({KC_ROTR, KC_ROTL, KC_SOFTDROP, KC_KONAMI, KC_RIGHT, KC_LEFT}),
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK = NUM_KEYS'(6'b000011),
    parameter int DAS_DELAY = DAS_DEFAULT,
    parameter int ARR_PERIOD = ARR_DEFAULT,
    localparam int IDX_W = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [KEYCODE_W-1:0] keyboardinput,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 ev_ready,
    output logic                 ev_valid,
    output logic [IDX_W-1:0]     ev_idx,
    output logic [NUM_KEYS-1:0]  pending,
    output logic [NUM_KEYS-1:0]  held
);
    logic [NUM_KEYS-1:0] match, held_d, press, rep, set, xfer;
    key_repeat_timer #(
        .NUM_KEYS(NUM_KEYS),
        .REPEAT_MASK(REPEAT_MASK),
        .DAS_DELAY(DAS_DELAY),
        .ARR_PERIOD(ARR_PERIOD)
    ) u_timer (
        .clk(CLK),
        .rst(RESET),
        .held(held),
        .press(press),
        .rep(rep)
    );
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            match[i] = keyboardinput == KEYMAP[KEYCODE_W*i +: KEYCODE_W];
    end
    always_comb begin
        ev_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (pending[i]) ev_idx = IDX_W'(i);
    end
    assign press = held & ~held_d;
    assign set = enable ? (press | rep) : '0;
    assign ev_valid = |pending;
    assign xfer = (ev_valid && ev_ready) ? NUM_KEYS'(1) << ev_idx : '0;
    // a set landing on the bit being transferred wins, so no event is lost
    always_ff @(posedge CLK) begin
        if (RESET) begin
            held <= '0;
            held_d <= '0;
            pending <= '0;
        end else begin
            held <= match;
            held_d <= held;
            pending <= flush ? '0 : ((pending & ~xfer) | set);
        end
    end
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed vectors for the key event arbiter with hand-computed expectations.
module tb_key_event_arbiter;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] keyboardinput = '0;
    logic       enable = 1'b1;
    logic       flush = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [2:0] ev_idx;
    logic [5:0] pending;
    logic [5:0] held;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xch[6] = '{default: 0};
    int xt[$];
    int b, n0, n5;
    int dly[5] = '{0, 16, 20, 24, 28};

    key_event_arbiter dut (
        .CLK(CLK),
        .RESET(RESET),
        .keyboardinput(keyboardinput),
        .enable(enable),
        .flush(flush),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_idx(ev_idx),
        .pending(pending),
        .held(held)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ev_valid && ev_ready) begin
            xch[int'(ev_idx)]++;
            xt.push_back(cyc);
        end
        cyc++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        tick(2);
        check("rst_pending", int'(pending), 0);
        check("rst_held", int'(held), 0);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_idx", int'(ev_idx), 0);
        RESET = 1'b0;

        // tap left for three cycles
        keyboardinput = 8'h04;
        tick();
        check("tap_held", int'(held), 6'b000001);
        check("tap_valid_e0", int'(ev_valid), 0);
        tick();
        check("tap_valid_e1", int'(ev_valid), 1);
        check("tap_idx", int'(ev_idx), 0);
        check("tap_pending", int'(pending), 6'b000001);
        ev_ready = 1'b1;
        tick();
        check("tap_cleared", int'(pending), 0);
        keyboardinput = '0;
        tick(5);
        check("tap_events", xch[0], 1);

        // hold right for 30 cycles with ready tied high
        b = xt.size();
        keyboardinput = 8'h07;
        tick(30);
        keyboardinput = '0;
        tick(20);
        check("rpt_count", xt.size() - b, 5);
        check("rpt_ch1", xch[1], 5);
        if (xt.size() - b == 5)
            for (int i = 1; i < 5; i++)
                check("rpt_spacing", xt[b+i] - xt[b], dly[i]);

        // rotate left never repeats
        keyboardinput = 8'h14;
        tick(40);
        keyboardinput = '0;
        tick(5);
        check("rotl_events", xch[4], 1);

        // two channels pending, lowest index first
        ev_ready = 1'b0;
        keyboardinput = 8'h08;
        tick();
        keyboardinput = 8'h07;
        tick();
        keyboardinput = '0;
        tick(3);
        check("prio_pending", int'(pending), 6'b100010);
        check("prio_idx1", int'(ev_idx), 1);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("prio_idx5", int'(ev_idx), 5);
        check("prio_pending5", int'(pending), 6'b100000);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("prio_empty", int'(ev_valid), 0);

        // repeat set coinciding with transfer of channel 0
        n0 = xch[0];
        keyboardinput = 8'h04;
        tick(17);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        keyboardinput = '0;
        check("coll_pending", int'(pending[0]), 1);
        check("coll_first", xch[0] - n0, 1);
        ev_ready = 1'b1;
        tick(3);
        ev_ready = 1'b0;
        check("coll_second", xch[0] - n0, 2);
        check("coll_empty", int'(pending), 0);

        // flush on the press-set edge
        keyboardinput = 8'h07;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_pending", int'(pending), 0);
        keyboardinput = '0;
        tick(3);
        check("flush_after", int'(pending), 0);

        // enable low blocks new sets but keeps pending deliverable
        n5 = xch[5];
        keyboardinput = 8'h08;
        tick(2);
        keyboardinput = '0;
        tick();
        check("en_pre", int'(pending), 6'b100000);
        enable = 1'b0;
        n0 = xch[0];
        keyboardinput = 8'h04;
        tick(2);
        keyboardinput = '0;
        tick(2);
        check("en_blocked", int'(pending), 6'b100000);
        check("en_idx", int'(ev_idx), 5);
        enable = 1'b1;
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("en_delivered", xch[5] - n5, 1);
        check("en_no_left", xch[0] - n0, 0);
        check("en_empty", int'(pending), 0);

        // reset while a key is held
        keyboardinput = 8'h04;
        tick(3);
        check("mid_pre", int'(pending), 6'b000001);
        RESET = 1'b1;
        tick();
        check("mid_held", int'(held), 0);
        check("mid_pending", int'(pending), 0);
        RESET = 1'b0;
        tick();
        check("mid_held_again", int'(held), 6'b000001);
        check("mid_pending_e0", int'(pending), 0);
        tick();
        check("mid_pending_e1", int'(pending), 6'b000001);
        keyboardinput = '0;
        ev_ready = 1'b1;
        tick(3);
        ev_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
